// File: rtl/run_det_pkg.sv
// Shared types and widths for the run_detector block: FSM states, counter widths.
package run_det_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_t;

  // Width of the tick counter; never below 1 so the counter always exists.
  function automatic int tick_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// Board-facing signal bundle of run_detector. With RUN_DET_STEP_EN defined it also
// carries the single-step button input.
// No handshake: w/step are free-running levels, tick/z/state/run_cnt are plain status outputs.
interface run_detector_if;
  import run_det_pkg::*;

  logic               w;
  logic               tick;
  logic               z;
  state_t             state;
  logic [CNT_W-1:0]   run_cnt;
`ifdef RUN_DET_STEP_EN
  logic               step;
`endif

  modport master (
    output w,
`ifdef RUN_DET_STEP_EN
    output step,
`endif
    input  tick, z, state, run_cnt
  );

  modport slave (
    input  w,
`ifdef RUN_DET_STEP_EN
    input  step,
`endif
    output tick, z, state, run_cnt
  );
endinterface

// File: rtl/run_detector_tick_gen.sv
// Free-running sample-tick generator: counts 0..TICK_DIV-1 and flags the last count.
module tick_gen
  import run_det_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int            TW   = tick_w(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge CLOCK_50) begin
    if (reset)       r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/run_detector.sv
// Run-length detector: asserts z once RUN_LEN consecutive tick-sampled values of w match.
// Optional RUN_DET_STEP_EN adds a synchronized step button that advances the FSM once per press.
module run_detector
  import run_det_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int RUN_LEN  = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  run_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] RL = CNT_W'(RUN_LEN);

  logic             w_tick;
  logic             w_adv;
  logic             r_w_meta;
  logic             r_w_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_z;
  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (w_tick)
  );

`ifdef RUN_DET_STEP_EN
  logic r_step_meta;
  logic r_step_s;
  logic r_step_d;
  logic w_step_rise;

  assign w_step_rise = r_step_s & ~r_step_d;
  // A press landing on a tick still yields exactly one advance.
  assign w_adv       = w_tick | w_step_rise;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_step_meta <= 1'b0;
      r_step_s    <= 1'b0;
      r_step_d    <= 1'b0;
    end else begin
      r_step_meta <= bus.step;
      r_step_s    <= r_step_meta;
      r_step_d    <= r_step_s;
    end
  end
`else
  assign w_adv = w_tick;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_run_cnt;
    unique case (r_state)
      IDLE: begin
        w_next_state = r_w_s ? RUN1 : RUN0;
        w_next_cnt   = CNT_W'(1);
      end
      RUN0, RUN1: begin
        if ((r_state == RUN1) == r_w_s) begin
          w_next_cnt = (r_run_cnt >= RL) ? RL : r_run_cnt + 1'b1;
        end else begin
          w_next_state = r_w_s ? RUN1 : RUN0;
          w_next_cnt   = CNT_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_w_meta  <= 1'b0;
      r_w_s     <= 1'b0;
      r_state   <= IDLE;
      r_run_cnt <= '0;
      r_z       <= 1'b0;
    end else begin
      r_w_meta <= bus.w;
      r_w_s    <= r_w_meta;
      if (w_adv) begin
        r_state   <= w_next_state;
        r_run_cnt <= w_next_cnt;
        r_z       <= (w_next_cnt == RL);
      end
    end
  end

  assign bus.tick    = w_tick;
  assign bus.state   = r_state;
  assign bus.run_cnt = r_run_cnt;
  assign bus.z       = r_z;

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector (TICK_DIV=4, RUN_LEN=3) against a sample-history model.
module tb_run_detector;
  import run_det_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int RUN_LEN  = 3;

  logic clk;
  logic reset;
  run_detector_if bus ();

  run_detector #(.TICK_DIV(TICK_DIV), .RUN_LEN(RUN_LEN)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          phase  = 0;
  int          rise_cd = -1;
  logic [0:0]  exp_q[$];

  function automatic int model_run();
    int n = 0;
    if (exp_q.size() == 0) return 0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i] == exp_q[exp_q.size() - 1]) n++;
      else break;
    end
    return (n > RUN_LEN) ? RUN_LEN : n;
  endfunction

  task automatic check_outputs(input string tag);
    int         run;
    logic [1:0] exp_state;
    logic [1:0] act_state;
    logic       exp_z;
    run       = model_run();
    exp_state = (exp_q.size() == 0) ? 2'd0 : (exp_q[exp_q.size() - 1] ? 2'd2 : 2'd1);
    exp_z     = (run == RUN_LEN);
    act_state = bus.state;
    checks++;
    if (act_state !== exp_state) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", tag, act_state, exp_state);
    end
    checks++;
    if (bus.run_cnt !== 4'(run)) begin
      errors++;
      $display("FAIL %s run_cnt: got %0d expected %0d", tag, bus.run_cnt, run);
    end
    checks++;
    if (bus.z !== exp_z) begin
      errors++;
      $display("FAIL %s z: got %b expected %b", tag, bus.z, exp_z);
    end
  endtask

  // One clock cycle: check tick for the current cycle, then the registered outputs after the edge.
  task automatic clk_cycle(input string tag);
    logic exp_tick;
    logic exp_adv;
    exp_tick = (phase == TICK_DIV - 1);
    exp_adv  = exp_tick;
    if (rise_cd == 0) exp_adv = 1'b1;
    if (rise_cd >= 0) rise_cd--;
    checks++;
    if (bus.tick !== exp_tick) begin
      errors++;
      $display("FAIL %s tick phase %0d: got %b expected %b", tag, phase, bus.tick, exp_tick);
    end
    if (exp_adv) exp_q.push_back(bus.w);
    @(posedge clk); #1;
    phase = (phase + 1) % TICK_DIV;
    check_outputs(tag);
  endtask

  task automatic run_ticks(input int n, input string tag);
    int seen = 0;
    while (seen < n) begin
      if (phase == TICK_DIV - 1) seen++;
      clk_cycle(tag);
    end
  endtask

  task automatic advance_to_phase(input int p, input string tag);
    while (phase != p) clk_cycle(tag);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    reset   = 1'b0;
    phase   = 0;
    rise_cd = -1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.w = 1'b0;
    do_reset(5);
    check_outputs("reset");
    run_ticks(3, "reset_ticks");
  endtask

  task automatic test_run_ones();
    do_reset(2);
    bus.w = 1'b1;
    run_ticks(3, "ones");
    checks++;
    if (bus.z !== 1'b1 || bus.run_cnt !== 4'd3) begin
      errors++;
      $display("FAIL ones_sat: got z=%b cnt=%0d expected z=1 cnt=3", bus.z, bus.run_cnt);
    end
    run_ticks(2, "ones_hold");
  endtask

  task automatic test_alternating();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      bus.w = (i % 2 == 0) ? 1'b1 : 1'b0;
      run_ticks(1, "alt");
      checks++;
      if (bus.z !== 1'b0) begin
        errors++;
        $display("FAIL alt_z: got %b expected 0", bus.z);
      end
    end
  endtask

  task automatic test_zeros_break();
    do_reset(2);
    bus.w = 1'b0;
    run_ticks(3, "zeros");
    bus.w = 1'b1;
    run_ticks(1, "break");
  endtask

  task automatic test_reset_mid_run();
    do_reset(2);
    bus.w = 1'b1;
    run_ticks(2, "mid_pre");
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    phase   = 0;
    exp_q.delete();
    check_outputs("mid_reset");
    run_ticks(2, "mid_post");
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 30; i++) begin
      bus.w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        phase = 0;
        exp_q.delete();
        check_outputs("rand_reset");
      end
      run_ticks(1, "rand");
    end
  endtask

`ifdef RUN_DET_STEP_EN
  task automatic test_step();
    logic [3:0] before;
    bus.step = 1'b0;
    do_reset(2);
    bus.w = 1'b1;
    run_ticks(1, "step_pre");
    bus.step = 1'b1;
    rise_cd  = 2;
    run_ticks(2, "step_held");
    bus.step = 1'b0;
    bus.w    = 1'b0;
    repeat (4) clk_cycle("step_rel");
    advance_to_phase(1, "step_align");
    for (int k = 0; k < 2; k++) begin
      before   = bus.run_cnt;
      bus.step = 1'b1;
      rise_cd  = 2;
      run_ticks(1, "step_coinc");
      checks++;
      if (bus.run_cnt !== ((k == 0) ? 4'd1 : before + 4'd1)) begin
        errors++;
        $display("FAIL step_coinc: got %0d from %0d", bus.run_cnt, before);
      end
      bus.step = 1'b0;
      repeat (4) clk_cycle("step_rel2");
      advance_to_phase(1, "step_align2");
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.w = 1'b0;
`ifdef RUN_DET_STEP_EN
    bus.step = 1'b0;
`endif
    test_reset();
    test_run_ones();
    test_alternating();
    test_zeros_break();
    test_reset_mid_run();
    test_random();
`ifdef RUN_DET_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
